pipe_stage_reg: RTL and testbench

Parametrised, elastic pipeline-stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB) carrying an arbitrary packed payload.
Adds a valid/ready handshake, a synchronous flush for branch/jump squash, and NOP substitution on bubbles, none of which a plain enable-gated stage register provides.
Optional 2-entry skid mode registers the upstream ready so ready paths do not chain combinationally across stages.

---
 rtl/pipe_stage_reg.sv | 126 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, synchronous flush and NOP bubbles.
// SKID=1 gives a 2-entry skid buffer with registered in_ready; SKID=0 a single combinational entry.
module pipe_stage_reg #(
   parameter int unsigned       WIDTH     = 32,
   parameter logic [WIDTH-1:0]  NOP_VALUE = '0,
   parameter int unsigned       SKID      = 1
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

   if (SKID != 0) begin : g_skid
      state_e           state_q, state_d;
      logic [WIDTH-1:0] main_q, main_d;
      logic [WIDTH-1:0] skid_q, skid_d;
      logic             in_ready_q, in_ready_d;
      logic             in_xfer, out_xfer;

      always_ff @(posedge CLK or negedge nRST) begin
         if (!nRST) begin
            state_q    <= StEmpty;
            main_q     <= NOP_VALUE;
            skid_q     <= NOP_VALUE;
            in_ready_q <= 1'b1;
         end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
         end
      end

      always_comb begin
         state_d  = state_q;
         main_d   = main_q;
         skid_d   = skid_q;
         in_xfer  = in_valid & in_ready_q;
         out_xfer = (state_q != StEmpty) & out_ready;
         unique case (state_q)
            StEmpty: begin
               if (in_xfer) begin
                  state_d = StOne;
                  main_d  = in_data;
               end
            end
            StOne: begin
               if (in_xfer && out_xfer) begin
                  main_d = in_data;
               end else if (in_xfer) begin
                  state_d = StTwo;
                  skid_d  = in_data;
               end else if (out_xfer) begin
                  state_d = StEmpty;
               end
            end
            StTwo: begin
               if (out_xfer) begin
                  state_d = StOne;
                  main_d  = skid_q;
               end
            end
            default: state_d = StEmpty;
         endcase
         // Flush overrides everything; a same-cycle input is simply never recorded as held.
         if (flush) begin
            state_d = StEmpty;
         end
         in_ready_d = (state_d != StTwo);
      end

      always_comb begin
         in_ready  = in_ready_q;
         out_valid = (state_q != StEmpty);
         out_data  = out_valid ? main_q : NOP_VALUE;
         occupancy = (state_q == StTwo) ? 2'd2 : (state_q == StOne) ? 2'd1 : 2'd0;
      end
   end else begin : g_single
      logic             valid_q, valid_d;
      logic [WIDTH-1:0] main_q, main_d;
      logic             in_xfer, out_xfer;

      always_ff @(posedge CLK or negedge nRST) begin
         if (!nRST) begin
            valid_q <= 1'b0;
            main_q  <= NOP_VALUE;
         end else begin
            valid_q <= valid_d;
            main_q  <= main_d;
         end
      end

      always_comb begin
         in_ready = ~valid_q | out_ready;
         in_xfer  = in_valid & in_ready;
         out_xfer = valid_q & out_ready;
         valid_d  = valid_q;
         main_d   = main_q;
         if (in_xfer) begin
            valid_d = 1'b1;
            main_d  = in_data;
         end else if (out_xfer) begin
            valid_d = 1'b0;
         end
         if (flush) begin
            valid_d = 1'b0;
         end
      end

      always_comb begin
         out_valid = valid_q;
         out_data  = valid_q ? main_q : NOP_VALUE;
         occupancy = {1'b0, valid_q};
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance share stimulus, each checked
// every cycle against a queue model, plus hand-computed literal expectations.
module tb_pipe_stage_reg;
   localparam int unsigned      W   = 32;
   localparam logic [W-1:0]     NOP = '0;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] in_data = '0;

   logic         a_in_ready, a_out_valid, b_in_ready, b_out_valid;
   logic [W-1:0] a_out_data, b_out_data;
   logic [1:0]   a_occ, b_occ;

   int vectors = 0;
   int miscompares = 0;

   logic [W-1:0] qa[$];
   logic [W-1:0] qb[$];
   bit           a_acc, b_acc;
   logic [W-1:0] vals [4];

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(W), .NOP_VALUE(NOP), .SKID(1)) u_skid (
      .CLK(clk), .nRST(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
      .occupancy(a_occ)
   );

   pipe_stage_reg #(.WIDTH(W), .NOP_VALUE(NOP), .SKID(0)) u_single (
      .CLK(clk), .nRST(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
      .occupancy(b_occ)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each stage is a FIFO of capacity 2 (skid) or 1 (single).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qa.delete();
         qb.delete();
      end else begin
         a_acc = in_valid && (qa.size() < 2);
         b_acc = in_valid && (qb.size() == 0 || out_ready);
         if (qa.size() > 0 && out_ready) void'(qa.pop_front());
         if (qb.size() > 0 && out_ready) void'(qb.pop_front());
         if (flush) begin
            qa.delete();
            qb.delete();
         end else begin
            if (a_acc) qa.push_back(in_data);
            if (b_acc) qb.push_back(in_data);
         end
      end
   end

   always @(negedge clk) begin
      chk("a_valid", a_out_valid, qa.size() > 0);
      chk("a_data", a_out_data, (qa.size() > 0) ? qa[0] : NOP);
      chk("a_occ", a_occ, qa.size());
      chk("a_in_ready", a_in_ready, qa.size() < 2);
      chk("b_valid", b_out_valid, qb.size() > 0);
      chk("b_data", b_out_data, (qb.size() > 0) ? qb[0] : NOP);
      chk("b_occ", b_occ, qb.size());
      chk("b_in_ready", b_in_ready, (qb.size() == 0) || out_ready);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
      step();
      step();
      #1;
      chk("lit_rst_a_valid", a_out_valid, 1'b0);
      chk("lit_rst_a_data", a_out_data, 32'h0);
      chk("lit_rst_a_ready", a_in_ready, 1'b1);
      chk("lit_rst_a_occ", a_occ, 2'd0);
      chk("lit_rst_b_data", b_out_data, 32'h0);
      rst_n = 1'b1;
      step();

      // Streaming at full rate
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; out_ready = 1'b1; in_data = vals[i];
         step();
         #1;
         chk("lit_stream_a_data", a_out_data, vals[i]);
         chk("lit_stream_a_occ", a_occ, 2'd1);
         chk("lit_stream_b_data", b_out_data, vals[i]);
      end
      in_valid = 1'b0;
      step();

      // Fill skid with downstream stalled
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA1;
      step();
      in_data = 32'hA2;
      step();
      #1;
      chk("lit_fill_a_occ", a_occ, 2'd2);
      chk("lit_fill_a_ready", a_in_ready, 1'b0);
      chk("lit_fill_a_data", a_out_data, 32'hA1);
      chk("lit_full_b_ready", b_in_ready, 1'b0);
      out_ready = 1'b1;
      #1;
      chk("lit_repl_b_ready", b_in_ready, 1'b1);
      step();
      #1;
      chk("lit_pop_a_data", a_out_data, 32'hA2);
      chk("lit_pop_a_ready", a_in_ready, 1'b1);
      chk("lit_repl_b_data", b_out_data, 32'hA2);
      in_valid = 1'b0;
      step();

      // Flush while full with a competing input
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hC1;
      step();
      in_data = 32'hC2;
      step();
      flush = 1'b1; in_data = 32'hBB;
      step();
      #1;
      chk("lit_flush_a_valid", a_out_valid, 1'b0);
      chk("lit_flush_a_data", a_out_data, NOP);
      chk("lit_flush_a_occ", a_occ, 2'd0);
      chk("lit_flush_a_ready", a_in_ready, 1'b1);
      chk("lit_flush_b_valid", b_out_valid, 1'b0);
      flush = 1'b0; in_valid = 1'b0;
      step();
      step();

      // Asynchronous reset mid-stream
      in_valid = 1'b1; in_data = 32'hD1;
      step();
      in_data = 32'hD2;
      step();
      rst_n = 1'b0;
      #1;
      chk("lit_arst_a_valid", a_out_valid, 1'b0);
      chk("lit_arst_a_occ", a_occ, 2'd0);
      chk("lit_arst_a_ready", a_in_ready, 1'b1);
      chk("lit_arst_a_data", a_out_data, NOP);
      in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      in_valid = 1'b1; out_ready = 1'b1; in_data = 32'hE1;
      step();
      #1;
      chk("lit_resume_a_data", a_out_data, 32'hE1);
      in_data = 32'hE2;
      step();
      #1;
      chk("lit_resume_b_data", b_out_data, 32'hE2);
      in_valid = 1'b0;
      step();

      // Mixed stalls and bubbles with a flush in the middle
      for (int i = 0; i < 48; i++) begin
         in_valid  = (i % 3) != 0;
         out_ready = (i % 4) < 2;
         flush     = (i == 29);
         in_data   = 32'hF000_0000 + i;
         step();
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
